// File: rtl/seven_segment_scan_controller.sv
// Multiplexed scan driver for a common-anode seven-segment bank.
// New values are staged and committed only at frame wrap or while idle.
module seven_segment_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    enable,
  input  logic                    lz_en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_tick
);

  localparam int CMAX = (DWELL_CYCLES > GUARD_CYCLES) ?
                        DWELL_CYCLES : GUARD_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] DLAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] GLAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {GUARD, SHOW} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] comm_val;
  logic [NUM_DIGITS-1:0]   comm_dp;
  logic [4*NUM_DIGITS-1:0] stg_val;
  logic [NUM_DIGITS-1:0]   stg_dp;
  logic                    full;

  logic [NUM_DIGITS-1:0]   lead;
  logic                    zero_above;
  logic [3:0]              nib;
  logic                    blank;
  logic [7:0]              show_seg;
  logic [NUM_DIGITS-1:0]   show_en;
  logic                    wrap;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // lead[i]: every nibble from the top down to i is zero
  always_comb begin
    zero_above = 1'b1;
    lead = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (comm_val[4*i +: 4] == 4'h0);
      lead[i] = zero_above && (i != 0);
    end
  end

  always_comb begin
    nib = comm_val[4*idx +: 4];
    blank = lz_en && lead[idx];
    show_seg = {~comm_dp[idx], blank ? 7'h7F : hex7(nib)};
    show_en = ~(NUM_DIGITS'(1) << idx);
    wrap = enable && (state == SHOW) &&
           (cnt == DLAST) && (idx == ILAST);
  end

  assign load_ready = ~full;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= GUARD;
      cnt        <= '0;
      idx        <= '0;
      comm_val   <= '0;
      comm_dp    <= '0;
      stg_val    <= '0;
      stg_dp     <= '0;
      full       <= 1'b0;
      seg        <= 8'hFF;
      dig_en     <= '1;
      frame_tick <= 1'b0;
    end else begin
      if (full && (wrap || !enable)) begin
        comm_val <= stg_val;
        comm_dp  <= stg_dp;
        full     <= 1'b0;
      end else if (load_valid && !full) begin
        stg_val <= load_data;
        stg_dp  <= load_dp;
        full    <= 1'b1;
      end

      if (!enable) begin
        state      <= GUARD;
        cnt        <= '0;
        idx        <= '0;
        seg        <= 8'hFF;
        dig_en     <= '1;
        frame_tick <= 1'b0;
      end else begin
        frame_tick <= 1'b0;
        seg        <= (state == SHOW) ? show_seg : 8'hFF;
        dig_en     <= (state == SHOW) ? show_en : '1;
        unique case (state)
          GUARD: begin
            if (cnt == GLAST) begin
              state <= SHOW;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHOW: begin
            if (cnt == DLAST) begin
              state      <= GUARD;
              cnt        <= '0;
              idx        <= (idx == ILAST) ? '0 : idx + 1'b1;
              frame_tick <= (idx == ILAST);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= GUARD;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
